// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding and bit-timing arithmetic used by tx and rx.
package uart_pkg;

  typedef enum logic [2:0] {
    STT_WAIT  = 3'd0,
    STT_START = 3'd1,
    STT_DATA  = 3'd2,
    STT_STOP  = 3'd3,
    STT_BREAK = 3'd4
  } rx_state_t;

  // Clocks per bit (integer division).
  function automatic int unsigned pulse_width(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Clocks to the middle of a bit.
  function automatic int unsigned half_pulse_width(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
    return pulse_width(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Device-facing UART bundle shared by uart_rx and uart_tx.
interface uart_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sig;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport rx (input sig, output data, output valid, input ready);
  modport tx (output sig, input data, input valid, output ready);
endinterface

// File: rtl/uart_sync.sv
// N-stage bit synchronizer for an asynchronous input, with a selectable reset value.
module uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= STAGES'({ff, d});
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit, no parity.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000
) (
  input  logic clk,
  input  logic rstn,
  uart_if.rx   rxif,
  output logic frame_err,
  output logic overrun
);

  localparam int unsigned PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_PULSE_WIDTH = half_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned LB_PULSE_WIDTH   = $clog2(PULSE_WIDTH);
  localparam int unsigned LB_DATA_WIDTH    = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W            = LB_PULSE_WIDTH + 1;
  localparam int unsigned BIT_W            = (LB_DATA_WIDTH > 0) ? LB_DATA_WIDTH : 1;

  logic                  s;
  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  tick_c;

  // Bring the serial line into the clk domain.
  uart_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxif.sig),
    .q    (s)
  );

  assign tick_c = (clk_cnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= STT_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counters, shift register and handshake outputs.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = tick_c ? clk_cnt_q : clk_cnt_q - CNT_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~rxif.ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      STT_WAIT: begin
        if (!s) begin
          state_d   = STT_START;
          clk_cnt_d = CNT_W'(HALF_PULSE_WIDTH - 1);
        end
      end

      STT_START: begin
        if (tick_c) begin
          if (s) begin
            state_d = STT_WAIT;
          end else begin
            state_d   = STT_DATA;
            clk_cnt_d = CNT_W'(PULSE_WIDTH - 1);
            bit_cnt_d = '0;
          end
        end
      end

      STT_DATA: begin
        if (tick_c) begin
          shift_d[bit_cnt_q] = s;
          clk_cnt_d          = CNT_W'(PULSE_WIDTH - 1);
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            state_d = STT_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      STT_STOP: begin
        if (tick_c) begin
          if (s) begin
            // A handshake in this same cycle frees the output for the new word.
            if (!valid_q || rxif.ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = STT_WAIT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = STT_BREAK;
          end
        end
      end

      STT_BREAK: begin
        if (s) begin
          state_d = STT_WAIT;
        end
      end

      default: begin
        state_d = STT_WAIT;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rxif.data  = data_q;
  assign rxif.valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: driver pushes expected words, monitor pops on each handshake.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 100_000_000;
  // Faster baud keeps the run short; all timing below scales with PW.
  localparam int unsigned BAUD_RATE = 1_000_000;
  localparam int          PW        = 100;
  localparam int          HPW       = 50;

  logic clk;
  logic rstn;
  logic frame_err;
  logic overrun;

  uart_if #(.DATA_WIDTH(8)) rxif ();

  uart_rx #(
    .DATA_WIDTH (8),
    .BAUD_RATE  (BAUD_RATE),
    .CLK_FREQ   (CLK_FREQ)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxif      (rxif),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int         tests;
  int         fails;
  int         hs_cnt;
  int         fe_cnt;
  int         ov_cnt;
  int         cyc;
  int         rise_cyc;
  int         stop_mid;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxif.sig = b;
    repeat (PW) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    stop_mid = cyc + HPW;
    drive_bit(stop);
  endtask

  task automatic wait_hs(input string name, input int target);
    int budget;
    budget = 4 * PW;
    while (hs_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    check(name, 32'(hs_cnt), 32'(target));
  endtask

  // Monitor: pops the scoreboard on every handshake and counts error pulses.
  task automatic run_monitor();
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (rxif.valid && !prev_valid) rise_cyc = cyc;
        if (rxif.valid && rxif.ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got 0x%0h expected none", rxif.data);
          end else begin
            check("rx_data", 32'(rxif.data), 32'(exp_q.pop_front()));
          end
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
      end
      prev_valid = rxif.valid;
    end
  endtask

  initial begin
    int hs0;
    tests      = 0;
    fails      = 0;
    hs_cnt     = 0;
    fe_cnt     = 0;
    ov_cnt     = 0;
    cyc        = 0;
    rise_cyc   = 0;
    stop_mid   = 0;
    rstn       = 1'b0;
    rxif.sig   = 1'b1;
    rxif.ready = 1'b1;

    fork
      run_monitor();
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_data", 32'(rxif.data), 32'h0);
    check("rst_valid", 32'(rxif.valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rstn = 1'b1;
    repeat (PW) tick();

    // 1: single frame 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_hs("t1_hs_count", 1);
    check("t1_latency_ok",
          32'((rise_cyc > stop_mid) && (rise_cyc - stop_mid < PW)), 32'h1);
    repeat (PW) tick();
    check("t1_frame_err", 32'(fe_cnt), 32'h0);
    check("t1_overrun", 32'(ov_cnt), 32'h0);

    // 2: back-to-back frames with exactly one stop bit
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    wait_hs("t2_hs_count", 4);
    repeat (PW) tick();

    // 3: short low glitch is ignored, then 0x3C
    rxif.sig = 1'b0;
    repeat (20) tick();
    rxif.sig = 1'b1;
    repeat (2 * PW) tick();
    check("t3_glitch_no_valid", 32'(hs_cnt), 32'd4);
    check("t3_glitch_no_ferr", 32'(fe_cnt), 32'h0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_hs("t3_hs_count", 5);
    repeat (PW) tick();

    // 4: framing error followed by a held-low break, then 0x42
    send_frame(8'h81, 1'b0);
    rxif.sig = 1'b0;
    repeat (5 * PW) tick();
    rxif.sig = 1'b1;
    repeat (2 * PW) tick();
    check("t4_frame_err_pulses", 32'(fe_cnt), 32'h1);
    check("t4_no_valid", 32'(hs_cnt), 32'd5);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_hs("t4_hs_count", 6);
    repeat (PW) tick();

    // 5: overrun with ready held low
    rxif.ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    repeat (PW) tick();
    check("t5_valid_held", 32'(rxif.valid), 32'h1);
    check("t5_data_first", 32'(rxif.data), 32'h11);
    send_frame(8'h22, 1'b1);
    repeat (PW) tick();
    check("t5_overrun_pulses", 32'(ov_cnt), 32'h1);
    check("t5_data_retained", 32'(rxif.data), 32'h11);
    check("t5_valid_still", 32'(rxif.valid), 32'h1);
    rxif.ready = 1'b1;
    wait_hs("t5_hs_count", 7);
    repeat (2) tick();
    check("t5_valid_cleared", 32'(rxif.valid), 32'h0);
    repeat (PW) tick();

    // 6: reset in the middle of data bit 3 abandons the frame
    hs0 = hs_cnt;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rxif.sig = 1'b0;
    repeat (HPW) tick();
    rstn = 1'b0;
    tick();
    check("t6_valid_after_rst", 32'(rxif.valid), 32'h0);
    rstn     = 1'b1;
    rxif.sig = 1'b1;
    repeat (3 * PW) tick();
    check("t6_no_partial_word", 32'(hs_cnt), 32'(hs0));
    exp_q.push_back(8'h9E);
    send_frame(8'h9E, 1'b1);
    wait_hs("t6_hs_count", hs0 + 1);
    repeat (2 * PW) tick();

    // Totals
    check("end_queue_empty", 32'(exp_q.size()), 32'h0);
    check("end_hs_total", 32'(hs_cnt), 32'd8);
    check("end_frame_err_total", 32'(fe_cnt), 32'h1);
    check("end_overrun_total", 32'(ov_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: deserializes the asynchronous line `rxif.sig` (8N1-style framing: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit, no parity) into parallel words.
- Presents each word on a valid/ready handshake.
- Sits at the device-facing edge, paired with uart_tx on the same uart_if bundle.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- DATA_WIDTH, 8, bits per frame.
- BAUD_RATE, 115200, line baud rate.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- localparam PULSE_WIDTH = CLK_FREQ/BAUD_RATE, clocks per bit (integer division).
- localparam HALF_PULSE_WIDTH = PULSE_WIDTH/2.
- localparam LB_PULSE_WIDTH = $clog2(PULSE_WIDTH).
- localparam LB_DATA_WIDTH = $clog2(DATA_WIDTH).

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; synchronous, active-low.
- rxif  uart_if.rx  -  rxif.sig (in, 1, serial line, idle high), rxif.data (out, DATA_WIDTH, received word), rxif.valid (out, 1), rxif.ready (in, 1).
- frame_err  output  1  one-cycle pulse: the stop bit was sampled low.
- overrun  output  1  one-cycle pulse: a frame completed while rxif.valid was still held.

Behaviour:
- Reset values (rstn=0 at posedge clk):
  - Outputs: rxif.data=0, rxif.valid=0, frame_err=0, overrun=0.
  - Internals: state=STT_WAIT; both sync flops=1; shift register=0; bit counter=0; clk_cnt=0.
  - Reset mid-frame abandons the frame; no valid is produced for it.
- Input synchronizer: 2-flop synchronizer on rxif.sig, reset to 1. All logic uses the synchronized value `s`. This adds 2 cycles of fixed latency.
- Counters:
  - clk_cnt is LB_PULSE_WIDTH+1 bits and counts down to 0.
  - An action fires in the cycle where clk_cnt==0; otherwise clk_cnt decrements.
- FSM states: STT_WAIT, STT_START, STT_DATA, STT_STOP, STT_BREAK.
  - STT_WAIT: on s==0 go to STT_START with clk_cnt=HALF_PULSE_WIDTH-1.
  - STT_START: at clk_cnt==0 (mid start bit) re-sample s.
    - s==1: glitch; return to STT_WAIT with no error.
    - s==0: go to STT_DATA with clk_cnt=PULSE_WIDTH-1 and bit counter=0.
  - STT_DATA: at each clk_cnt==0, shift s into the shift register at index [bit counter] (LSB first) and reload clk_cnt=PULSE_WIDTH-1.
    - When bit counter==DATA_WIDTH-1, go to STT_STOP; otherwise increment the bit counter.
  - STT_STOP: at clk_cnt==0, sample the stop bit.
    - s==1 and rxif.valid==0: rxif.data<=shift register, rxif.valid<=1 (asserted the cycle after the stop sample); go to STT_WAIT.
    - s==1 and rxif.valid==1: overrun pulses for 1 cycle; the new word is discarded and rxif.data is retained; go to STT_WAIT.
    - s==0: frame_err pulses for 1 cycle; the word is discarded; go to STT_BREAK.
  - STT_BREAK: wait until s==1, then go to STT_WAIT. This stops a held-low line (break) from retriggering frames.
  - Any illegal state: go to STT_WAIT.
- Sample timing: sampling is mid-bit. Data bit k is sampled HALF_PULSE_WIDTH + (k+1)*PULSE_WIDTH clocks after the falling edge is seen on s. Tolerance is about ±half a bit over the frame.
- Handshake:
  - rxif.valid rises only in the stop-sample path above.
  - rxif.valid clears on the cycle after any cycle with rxif.valid && rxif.ready.
  - rxif.data is stable while rxif.valid==1.
  - rxif.ready may be held high permanently.
  - Simultaneous stop sample (accept) and ready handshake on an old word: the old word is treated as consumed first, so the new word is accepted, rxif.valid stays 1, and no overrun is flagged.
- Back-to-back frames: a new start bit is accepted in the cycle after the stop sample (mid stop bit). This tolerates fast transmitters with short stop bits.
- The receiver never stalls the line: reception continues regardless of rxif.ready.

Decomposition:
- Shared package uart_pkg: the rx statetype enum (logic [2:0]), plus helper functions/constants for PULSE_WIDTH derivation, so tx and rx use identical arithmetic.
- One sub-module: uart_sync, a parameterized N-stage (default 2) bit synchronizer with a reset value parameter (1 here). It is reusable for other async inputs.
- The FSM, counters, and handshake stay in uart_rx.

Test Plan:
All cases use CLK_FREQ=100_000_000 and BAUD_RATE=115200, so PULSE_WIDTH=868 and HALF_PULSE_WIDTH=434.
1. Drive frame 0xA5 with ready=1 → one valid pulse with data=0xA5; frame_err=0; overrun=0; valid rises within PULSE_WIDTH of the stop bit's midpoint.
2. Drive 0x00, 0xFF, 0x55 back-to-back, each with a stop bit of exactly 1 bit, ready=1 → three handshakes in order, data 0x00, 0xFF, 0x55.
3. Drive a low glitch of 200 clocks on an idle line → no valid and no frame_err; the next frame 0x3C is received correctly.
4. Drive frame 0x81 with the stop bit forced low, then hold the line low for 5 bit times before returning high → one frame_err pulse, no valid; the following frame 0x42 is received.
5. Hold ready=0 and send 0x11 then 0x22 → data stays 0x11 with valid held; one overrun pulse at the second stop sample; on ready=1 a single handshake delivers 0x11.
6. Assert rstn=0 for 1 cycle in the middle of data bit 3 of a frame → valid=0; no partial word appears; the next complete frame 0x9E is received correctly.
